pwm_seq_ctrl: RTL and testbench
===============================

Name: pwm_seq_ctrl

Overview:
Duty-cycle sequencer and bus arbiter in front of the two-channel PWM peripheral. It owns the PWM register port and shares it between the host bus and an internal sequencer. The sequencer replays a programmed table of duty values into one PWM channel's DC register at a fixed cycle interval, giving fades and ramps without CPU involvement. Host accesses always take priority; sequencer writes wait for a free cycle.

Parameters:
DEPTH, 16, number of 16-bit duty-table entries (1..32; table occupies 0x80..0x80+4*DEPTH-4)
STEP_W, 24, width of the step-interval counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
host_re_i  in  1  host read strobe
host_we_i  in  1  host write strobe
host_addr_i  in  8  host byte address
host_wdata_i  in  32  host write data
host_be_i  in  4  host byte enables (forwarded; sequencer regs ignore it)
host_rdata_o  out  32  host read data (combinational)
pwm_re_o  out  1  read strobe to PWM
pwm_we_o  out  1  write strobe to PWM
pwm_addr_o  out  8  address to PWM
pwm_wdata_o  out  32  write data to PWM
pwm_be_o  out  4  byte enables to PWM
pwm_rdata_i  in  32  read data from PWM

Behaviour:
- Reset: async on rst_ni low. All registers, table, counter, index cleared; state IDLE; all pwm_*_o outputs 0.
- Address map: 0x00-0x3F pass through to PWM. 0x40 SEQ_CTRL: [0] enable, [1] loop, [2] chan (0 -> DC addr 12, 1 -> DC addr 28). 0x44 SEQ_STEP[STEP_W-1:0]. 0x48 SEQ_LEN[5:0]. 0x4C SEQ_STATUS (RO): [0] busy, [1] done, [12:8] index. 0x80+4i holds TABLE[i][15:0]. Unmapped addresses read 0 and ignore writes.
- Pass-through: a host access with addr<0x40 drives pwm_* = host_* combinationally, and host_rdata_o = pwm_rdata_i. Any other host access drives pwm_re_o = pwm_we_o = 0, and host_rdata_o = sequencer register value.
- Arbitration: a host access owns the PWM port when (host_re_i|host_we_i) and addr<0x40. The sequencer may write only in cycles without such an access. Host accesses to sequencer addresses do not block the sequencer.
- FSM states: IDLE, WRITE, WAIT, DONE.
  - IDLE/DONE -> WRITE on a host write to SEQ_CTRL with enable=1. This sets index=0 and clears done. If effective length is 0, go directly to DONE with done=1 and make no writes.
  - WRITE: when the port is free, assert pwm_we_o=1 for one cycle with addr = DC address of chan, wdata = {16'h0, TABLE[index]}, be=4'hF. If index==len_eff-1: with loop=1, index<=0 and go to WAIT; otherwise go to DONE with done=1. Else index++ and go to WAIT. If the port is blocked, stay in WRITE; stall length is unbounded.
  - WAIT: counter loads max(STEP,1)-1 on entry and decrements each cycle. WRITE is entered the cycle after the counter reads 0.
  - Net timing: uncontended writes occur exactly max(STEP,1)+1 cycles apart. The first write happens the cycle after the enable write.
- len_eff = min(SEQ_LEN, DEPTH).
- busy = 1 in WRITE or WAIT.
- Writing enable=0 forces IDLE next cycle, issues no further writes, and leaves done unchanged. The PWM keeps its last written DC.
- Writing SEQ_CTRL with enable=1 while busy restarts from index 0.
- TABLE, STEP and LEN may be written while running. A new value takes effect at the next table read, counter load, or end check respectively. chan is sampled at each write.

Optional Feature:
PWM_SEQ_IRQ_EN:
- Defined: adds port irq_o (out, 1) and SEQ_CTRL[3] irq_en.
  - SEQ_STATUS[2] irq_pend sets on the DONE transition, and also on each wrap when loop=1.
  - irq_pend is write-1-to-clear via a write to 0x4C bit 2. If set and clear happen in the same cycle, set wins.
  - irq_o = irq_pend & irq_en, registered; reset value 0.
- Undefined: no irq_o port; SEQ_CTRL[3] and SEQ_STATUS[2] read 0.

Decomposition:
- Shared package pwm_seq_pkg:
  - sequencer register offsets (0x40/0x44/0x48/0x4C, table base 0x80);
  - PWM DC addresses (12, 28) and the passthrough limit 0x40;
  - state encoding IDLE/WRITE/WAIT/DONE.
- One sub-module, pwm_seq_timer: loadable STEP_W down-counter with load, enable and zero outputs.

Test Plan:
- Reset mid-WAIT (rst_ni low 1 cycle) -> all pwm_*_o = 0, status = 0, no further writes.
- TABLE = {0x10, 0x20, 0x30}, LEN=3, STEP=4, chan=0, loop=0, enable -> pwm writes addr 12 with data 0x10, 0x20, 0x30 at cycles t+1, t+6, t+11, then done=1 and busy=0.
- Same setup with loop=1, chan=1 -> addr 28 write sequence 0x10, 0x20, 0x30, 0x10, ... every 5 cycles. Writing enable=0 -> no write afterwards.
- Host writes addr 4 continuously for 3 cycles while the sequencer is in WRITE -> host data forwarded unmodified, sequencer write delayed exactly 3 cycles, no lost entry.
- LEN=0 -> done=1 one cycle after enable, zero PWM writes. LEN=40 with DEPTH=16 -> 16 writes, then done.
- Host read of 0x08 returns pwm_rdata_i. Read of 0x4C returns {index, done, busy}. Read of 0x60 returns 0. With PWM_SEQ_IRQ_EN and irq_en=1, irq_o rises the cycle after DONE and clears after a W1C write to 0x4C.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared constants and state encoding for the PWM duty-cycle sequencer.
package pwm_seq_pkg;

  localparam logic [7:0] SEQ_CTRL_ADDR   = 8'h40;
  localparam logic [7:0] SEQ_STEP_ADDR   = 8'h44;
  localparam logic [7:0] SEQ_LEN_ADDR    = 8'h48;
  localparam logic [7:0] SEQ_STATUS_ADDR = 8'h4C;
  localparam logic [7:0] SEQ_TABLE_BASE  = 8'h80;

  localparam logic [7:0] PASS_LIMIT      = 8'h40;
  localparam logic [7:0] PWM_DC0_ADDR    = 8'd12;
  localparam logic [7:0] PWM_DC1_ADDR    = 8'd28;

  localparam int unsigned LEN_W = 6;
  localparam int unsigned IDX_W_STATUS = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pwm_seq_timer.sv
// Loadable down-counter that paces sequencer writes; holds at zero.
module pwm_seq_timer #(
  parameter int unsigned W = 24
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_seq_ctrl.sv
// PWM register-port arbiter plus duty-table sequencer.
// Optional interrupt support is enabled by defining PWM_SEQ_IRQ_EN.
module pwm_seq_ctrl
  import pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned STEP_W = 24
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        host_re_i,
  input  logic        host_we_i,
  input  logic [7:0]  host_addr_i,
  input  logic [31:0] host_wdata_i,
  input  logic [3:0]  host_be_i,
  output logic [31:0] host_rdata_o,
  output logic        pwm_re_o,
  output logic        pwm_we_o,
  output logic [7:0]  pwm_addr_o,
  output logic [31:0] pwm_wdata_o,
  output logic [3:0]  pwm_be_o,
`ifdef PWM_SEQ_IRQ_EN
  output logic        irq_o,
`endif
  input  logic [31:0] pwm_rdata_i
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  seq_state_e                state_q, state_d;
  logic [IDX_W_STATUS-1:0]   index_q, index_d;
  logic                      done_q, done_d;
  logic                      en_q, en_d;
  logic                      loop_q, loop_d;
  logic                      chan_q, chan_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [15:0]               tbl_q [DEPTH];
  logic [15:0]               tbl_d [DEPTH];
`ifdef PWM_SEQ_IRQ_EN
  logic                      irq_en_q, irq_en_d;
  logic                      irq_pend_q, irq_pend_d;
  logic                      irq_q, irq_d;
`endif

  logic              pass_addr, host_own, seq_wr, ctrl_wr, dis_wr, port_free;
  logic              tbl_hit;
  logic [LEN_W-1:0]  len_eff;
  logic              last;
  logic              seq_fire, tmr_load, tmr_en, tmr_zero;
  logic              wrap, to_done;
  logic [STEP_W-1:0] tmr_val;
  logic [31:0]       seq_rdata;
  logic              pend_bit, irq_en_bit;

  // Host decode and arbitration.
  always_comb begin
    pass_addr = (host_addr_i < PASS_LIMIT);
    host_own  = (host_re_i | host_we_i) & pass_addr;
    seq_wr    = host_we_i & ~pass_addr;
    ctrl_wr   = seq_wr & (host_addr_i == SEQ_CTRL_ADDR);
    dis_wr    = ctrl_wr & ~host_wdata_i[0];
    port_free = ~host_own & ~dis_wr;
    tbl_hit   = host_addr_i[7] & (host_addr_i[1:0] == 2'b00) &
                (6'(host_addr_i[6:2]) < 6'(DEPTH));
    len_eff   = (len_q > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_q;
    last      = ((LEN_W'(index_q) + LEN_W'(1)) >= len_eff);
    tmr_val   = (step_q == '0) ? '0 : step_q - STEP_W'(1);
  end

  // Sequencer FSM next-state; control writes override the running sequence.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    done_d   = done_q;
    seq_fire = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    wrap     = 1'b0;
    to_done  = 1'b0;
    case (state_q)
      ST_WRITE: begin
        if (port_free) begin
          seq_fire = 1'b1;
          tmr_load = 1'b1;
          if (last) begin
            if (loop_q) begin
              index_d = '0;
              wrap    = 1'b1;
              state_d = ST_WAIT;
            end else begin
              done_d  = 1'b1;
              to_done = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            index_d = index_q + IDX_W_STATUS'(1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d = ST_WRITE;
        end
      end
      default: ;
    endcase
    if (ctrl_wr) begin
      if (host_wdata_i[0]) begin
        index_d = '0;
        if (len_eff == '0) begin
          done_d  = 1'b1;
          to_done = 1'b1;
          state_d = ST_DONE;
        end else begin
          done_d  = 1'b0;
          to_done = 1'b0;
          state_d = ST_WRITE;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Host-writable configuration registers and duty table.
  always_comb begin
    en_d   = en_q;
    loop_d = loop_q;
    chan_d = chan_q;
    step_d = step_q;
    len_d  = len_q;
    tbl_d  = tbl_q;
    if (ctrl_wr) begin
      en_d   = host_wdata_i[0];
      loop_d = host_wdata_i[1];
      chan_d = host_wdata_i[2];
    end
    if (seq_wr && (host_addr_i == SEQ_STEP_ADDR)) begin
      step_d = host_wdata_i[STEP_W-1:0];
    end
    if (seq_wr && (host_addr_i == SEQ_LEN_ADDR)) begin
      len_d = host_wdata_i[LEN_W-1:0];
    end
    if (seq_wr && tbl_hit) begin
      tbl_d[host_addr_i[IDX_W+1:2]] = host_wdata_i[15:0];
    end
  end

`ifdef PWM_SEQ_IRQ_EN
  // Interrupt pending (set beats W1C) and registered interrupt output.
  always_comb begin
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    if (ctrl_wr) begin
      irq_en_d = host_wdata_i[3];
    end
    if (seq_wr && (host_addr_i == SEQ_STATUS_ADDR) && host_wdata_i[2]) begin
      irq_pend_d = 1'b0;
    end
    if (to_done || wrap) begin
      irq_pend_d = 1'b1;
    end
    irq_d = irq_pend_q & irq_en_q;
  end

  assign pend_bit   = irq_pend_q;
  assign irq_en_bit = irq_en_q;
  assign irq_o      = irq_q;
`else
  assign pend_bit   = 1'b0;
  assign irq_en_bit = 1'b0;
`endif

  // State and register storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      loop_q  <= 1'b0;
      chan_q  <= 1'b0;
      step_q  <= '0;
      len_q   <= '0;
      tbl_q   <= '{default: '0};
`ifdef PWM_SEQ_IRQ_EN
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      done_q  <= done_d;
      en_q    <= en_d;
      loop_q  <= loop_d;
      chan_q  <= chan_d;
      step_q  <= step_d;
      len_q   <= len_d;
      tbl_q   <= tbl_d;
`ifdef PWM_SEQ_IRQ_EN
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_d;
`endif
    end
  end

  // Step-interval pacing between sequencer writes.
  pwm_seq_timer #(
    .W (STEP_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  // Sequencer register readback.
  always_comb begin
    seq_rdata = '0;
    case (host_addr_i)
      SEQ_CTRL_ADDR:   seq_rdata = 32'({irq_en_bit, chan_q, loop_q, en_q});
      SEQ_STEP_ADDR:   seq_rdata = 32'(step_q);
      SEQ_LEN_ADDR:    seq_rdata = 32'(len_q);
      SEQ_STATUS_ADDR: seq_rdata = 32'({index_q, 5'b0, pend_bit, done_q,
                                        (state_q == ST_WRITE) || (state_q == ST_WAIT)});
      default: begin
        if (tbl_hit) begin
          seq_rdata = 32'(tbl_q[host_addr_i[IDX_W+1:2]]);
        end
      end
    endcase
  end

  // PWM port mux: host pass-through first, then the sequencer write.
  always_comb begin
    pwm_re_o     = 1'b0;
    pwm_we_o     = 1'b0;
    pwm_addr_o   = '0;
    pwm_wdata_o  = '0;
    pwm_be_o     = '0;
    host_rdata_o = pass_addr ? pwm_rdata_i : seq_rdata;
    if (host_own) begin
      pwm_re_o    = host_re_i;
      pwm_we_o    = host_we_i;
      pwm_addr_o  = host_addr_i;
      pwm_wdata_o = host_wdata_i;
      pwm_be_o    = host_be_i;
    end else if (seq_fire) begin
      pwm_we_o    = 1'b1;
      pwm_addr_o  = chan_q ? PWM_DC1_ADDR : PWM_DC0_ADDR;
      pwm_wdata_o = {16'h0, tbl_q[index_q[IDX_W-1:0]]};
      pwm_be_o    = 4'hF;
    end
  end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Scoreboard bench for pwm_seq_ctrl: stimulus queues expected PWM writes and
// host read data; a negedge monitor pops and compares them.
module tb_pwm_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        host_re_i, host_we_i;
  logic [7:0]  host_addr_i;
  logic [31:0] host_wdata_i;
  logic [3:0]  host_be_i;
  logic [31:0] host_rdata_o;
  logic        pwm_re_o, pwm_we_o;
  logic [7:0]  pwm_addr_o;
  logic [31:0] pwm_wdata_o;
  logic [3:0]  pwm_be_o;
  logic [31:0] pwm_rdata_i;
`ifdef PWM_SEQ_IRQ_EN
  logic        irq_o;
  localparam logic [31:0] P = 32'h4;
`else
  localparam logic [31:0] P = 32'h0;
`endif

  pwm_seq_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .host_re_i    (host_re_i),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_be_i    (host_be_i),
    .host_rdata_o (host_rdata_o),
    .pwm_re_o     (pwm_re_o),
    .pwm_we_o     (pwm_we_o),
    .pwm_addr_o   (pwm_addr_o),
    .pwm_wdata_o  (pwm_wdata_o),
    .pwm_be_o     (pwm_be_o),
`ifdef PWM_SEQ_IRQ_EN
    .irq_o        (irq_o),
`endif
    .pwm_rdata_i  (pwm_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } rd_t;

  wr_t wr_q[$];
  rd_t rd_q[$];
  int  total = 0;
  int  passed = 0;

  // Monitor: every PWM write and every host read is checked against the queues.
  always @(negedge clk_i) begin
    wr_t e;
    rd_t r;
    if (rst_ni) begin
      if (pwm_we_o) begin
        total++;
        if (wr_q.size() == 0) begin
          $display("FAIL unexpected_pwm_wr cyc=%0d got addr=%h data=%h be=%h",
                   cyc, pwm_addr_o, pwm_wdata_o, pwm_be_o);
        end else begin
          e = wr_q.pop_front();
          if (cyc == e.c && pwm_addr_o == e.addr && pwm_wdata_o == e.data &&
              pwm_be_o == e.be && !pwm_re_o) begin
            passed++;
          end else begin
            $display("FAIL pwm_wr got cyc=%0d addr=%h data=%h be=%h exp cyc=%0d addr=%h data=%h be=%h",
                     cyc, pwm_addr_o, pwm_wdata_o, pwm_be_o, e.c, e.addr, e.data, e.be);
          end
        end
      end
      if (host_re_i) begin
        total++;
        if (rd_q.size() == 0) begin
          $display("FAIL unexpected_rd cyc=%0d addr=%h", cyc, host_addr_i);
        end else begin
          r = rd_q.pop_front();
          if (host_rdata_o == r.data) passed++;
          else $display("FAIL rd_%h got %h exp %h", r.addr, host_rdata_o, r.data);
        end
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got %h exp %h", name, got, exp);
  endtask

  // One-cycle host write; pass-through writes are expected on the PWM port.
  task automatic hw(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    host_we_i = 1'b1; host_addr_i = a; host_wdata_i = d; host_be_i = be;
    if (a < 8'h40) wr_q.push_back('{cyc, a, d, be});
    @(posedge clk_i); #1;
    host_we_i = 1'b0; host_addr_i = '0; host_wdata_i = '0; host_be_i = '0;
  endtask

  task automatic hr(input logic [7:0] a, input logic [31:0] exp);
    host_re_i = 1'b1; host_addr_i = a;
    rd_q.push_back('{a, exp});
    @(posedge clk_i); #1;
    host_re_i = 1'b0; host_addr_i = '0;
  endtask

  task automatic exp_seq(input int c, input logic [7:0] a, input logic [31:0] d);
    wr_q.push_back('{c, a, d, 4'hF});
  endtask

  initial begin
    int t;
    rst_ni = 1'b0; host_re_i = 1'b0; host_we_i = 1'b0; host_addr_i = '0;
    host_wdata_i = '0; host_be_i = '0; pwm_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    chk("rst_pwm_we", 32'(pwm_we_o), 32'h0);
    chk("rst_pwm_bus", 32'({pwm_re_o, pwm_addr_o, pwm_be_o}) | pwm_wdata_o, 32'h0);
    cyc_wait(2);
    rst_ni = 1'b1;
    cyc_wait(1);
    hr(8'h4C, 32'h0);
    hr(8'h40, 32'h0);

    // Basic ramp: three entries, step 4, channel 0, no loop.
    hw(8'h80, 32'h10); hw(8'h84, 32'h20); hw(8'h88, 32'h30);
    hw(8'h48, 32'd3);  hw(8'h44, 32'd4);
    t = cyc;
    exp_seq(t + 1, 8'd12, 32'h10);
    exp_seq(t + 6, 8'd12, 32'h20);
    exp_seq(t + 11, 8'd12, 32'h30);
    hw(8'h40, 32'h1);
    cyc_wait(2);
    hr(8'h4C, 32'h0000_0101);
    cyc_wait(12);
    hr(8'h4C, 32'h0000_0202 | P);

    // Looping on channel 1, then disable mid-wait.
    t = cyc;
    exp_seq(t + 1,  8'd28, 32'h10);
    exp_seq(t + 6,  8'd28, 32'h20);
    exp_seq(t + 11, 8'd28, 32'h30);
    exp_seq(t + 16, 8'd28, 32'h10);
    exp_seq(t + 21, 8'd28, 32'h20);
    hw(8'h40, 32'h7);
    cyc_wait(22);
    hw(8'h40, 32'h6);
    cyc_wait(15);
    hr(8'h4C, 32'h0000_0200 | P);
    hr(8'h40, 32'h6);

    // Host contention: three pass-through writes stall the sequencer write.
    t = cyc;
    exp_seq(t + 1, 8'd12, 32'h10);
    hw(8'h40, 32'h1);
    cyc_wait(5);
    hw(8'h04, 32'hA5A5_0001, 4'h3);
    hw(8'h04, 32'hA5A5_0002, 4'hC);
    hw(8'h04, 32'hA5A5_0003, 4'hF);
    exp_seq(t + 9,  8'd12, 32'h20);
    exp_seq(t + 14, 8'd12, 32'h30);
    cyc_wait(8);

    // Zero length: done immediately, no PWM writes.
    hw(8'h48, 32'd0);
    hw(8'h40, 32'h1);
    hr(8'h4C, 32'h0000_0002 | P);
    cyc_wait(5);

    // Length beyond table depth clamps to 16 entries.
    for (int i = 0; i < 16; i++) hw(8'(8'h80 + 4 * i), 32'(16'h100 + i));
    hw(8'h48, 32'd40); hw(8'h44, 32'd1);
    t = cyc;
    for (int k = 0; k < 16; k++) exp_seq(t + 1 + 2 * k, 8'd12, 32'(16'h100 + k));
    hw(8'h40, 32'h1);
    cyc_wait(32);
    hr(8'h4C, 32'h0000_0F02 | P);

    // Register map reads and pass-through read data.
    hr(8'h8C, 32'h103);
    hr(8'hC0, 32'h0);
    hr(8'h81, 32'h0);
    hr(8'h48, 32'd40);
    hr(8'h44, 32'd1);
    hr(8'h40, 32'h1);
    hw(8'h60, 32'hFFFF_FFFF);
    hr(8'h60, 32'h0);
    hr(8'h08, 32'hDEAD_BEEF);
    pwm_rdata_i = 32'h1234_5678;
    hr(8'h3C, 32'h1234_5678);

`ifdef PWM_SEQ_IRQ_EN
    // Interrupt raises one cycle after DONE and clears after W1C.
    hw(8'h4C, 32'h4);
    hw(8'h48, 32'd0);
    hw(8'h40, 32'h9);
    @(negedge clk_i);
    chk("irq_before", 32'(irq_o), 32'h0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("irq_rise", 32'(irq_o), 32'h1);
    @(posedge clk_i); #1;
    hw(8'h4C, 32'h4);
    cyc_wait(1);
    @(negedge clk_i);
    chk("irq_clear", 32'(irq_o), 32'h0);
    @(posedge clk_i); #1;
`endif

    // Reset while waiting between writes.
    hw(8'h48, 32'd3); hw(8'h44, 32'd4);
    t = cyc;
    exp_seq(t + 1, 8'd12, 32'h100);
    hw(8'h40, 32'h1);
    cyc_wait(2);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("midrst_pwm_we", 32'(pwm_we_o), 32'h0);
    chk("midrst_pwm_bus", 32'({pwm_re_o, pwm_addr_o, pwm_be_o}) | pwm_wdata_o, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cyc_wait(20);
    hr(8'h4C, 32'h0);
    hr(8'h40, 32'h0);
    hr(8'h80, 32'h0);
    hr(8'h44, 32'h0);

    cyc_wait(2);
    total++;
    if (wr_q.size() == 0 && rd_q.size() == 0) passed++;
    else $display("FAIL leftover_expect got wr=%0d rd=%0d exp 0", wr_q.size(), rd_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
